// File: rtl/proc_run_controller.sv
// Run sequencer: resets the processor, runs it to an end PC, then
// captures writeback data and grades it against a pass code.
module proc_run_controller #(
   parameter int PC_W         = 64,
   parameter int DATA_W       = 64,
   parameter int RESET_CYCLES = 1,
   parameter int WDOG_W       = 16,
   parameter int WDOG_LIMIT   = 255
) (
   input  logic              CLK,
   input  logic              resetl,
   input  logic              start,
   input  logic [PC_W-1:0]   start_pc,
   input  logic [PC_W-1:0]   end_pc,
   input  logic [DATA_W-1:0] expected,
   input  logic [PC_W-1:0]   currentpc,
   input  logic [DATA_W-1:0] WB_data,
   output logic              proc_resetl,
   output logic [PC_W-1:0]   proc_startpc,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [DATA_W-1:0] result,
   output logic [WDOG_W-1:0] cycle_count
);

   localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RC_W-1:0]   RC_LOAD = RC_W'(RESET_CYCLES - 1);
   localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(WDOG_LIMIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [PC_W-1:0]   start_pc_q;
   logic [PC_W-1:0]   end_pc_q;
   logic [DATA_W-1:0] exp_q;
   logic [RC_W-1:0]   rst_cnt;

   logic accept;
   logic drain_exit;
   logic wd_exit;
   logic cnt_inc;

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      drain_exit = 1'b0;
      wd_exit    = 1'b0;
      cnt_inc    = 1'b0;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RESET;
            end
         end
         S_RESET: begin
            if (rst_cnt == '0)
               state_nxt = S_RUN;
         end
         S_RUN: begin
            // reaching the end PC wins over a same-cycle watchdog hit
            if (currentpc >= end_pc_q) begin
               state_nxt = S_DRAIN;
            end else if (cycle_count == WD_LAST) begin
               wd_exit   = 1'b1;
               state_nxt = S_DONE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_DRAIN: begin
            drain_exit = 1'b1;
            state_nxt  = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign proc_resetl  = (state == S_RUN) || (state == S_DRAIN) ||
                         (state == S_DONE);
   assign busy         = (state == S_RESET) || (state == S_RUN) ||
                         (state == S_DRAIN);
   assign proc_startpc = start_pc_q;

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state       <= S_IDLE;
         start_pc_q  <= '0;
         end_pc_q    <= '0;
         exp_q       <= '0;
         rst_cnt     <= '0;
         done        <= 1'b0;
         pass        <= 1'b0;
         timeout     <= 1'b0;
         result      <= '0;
         cycle_count <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            start_pc_q  <= start_pc;
            end_pc_q    <= end_pc;
            exp_q       <= expected;
            rst_cnt     <= RC_LOAD;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            result      <= '0;
            cycle_count <= '0;
         end
         if (state == S_RESET && rst_cnt != '0)
            rst_cnt <= rst_cnt - RC_W'(1);
         if (cnt_inc && cycle_count != '1)
            cycle_count <= cycle_count + WDOG_W'(1);
         if (wd_exit) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            pass    <= 1'b0;
            result  <= WB_data;
         end
         if (drain_exit) begin
            result <= WB_data;
            pass   <= (WB_data == exp_q);
            done   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_proc_run_controller.sv
// Bench for proc_run_controller with a PC-stepping processor model
// and a scoreboard of expected run outcomes.
module tb_proc_run_controller;

   localparam int RC = 1;

   logic        CLK = 1'b0;
   logic        resetl;
   logic        start;
   logic [63:0] start_pc;
   logic [63:0] end_pc;
   logic [63:0] expected;
   logic [63:0] currentpc;
   logic [63:0] WB_data;
   logic        proc_resetl;
   logic [63:0] proc_startpc;
   logic        busy;
   logic        done;
   logic        pass;
   logic        timeout;
   logic [63:0] result;
   logic [15:0] cycle_count;

   logic [63:0] model_pc;
   logic        stuck;
   logic [63:0] stuck_pc;
   logic [63:0] model_end;
   logic [63:0] code;

   typedef struct packed {
      logic        pass;
      logic        timeout;
      logic [63:0] result;
      logic [15:0] cc;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   proc_run_controller dut (
      .CLK(CLK),
      .resetl(resetl),
      .start(start),
      .start_pc(start_pc),
      .end_pc(end_pc),
      .expected(expected),
      .currentpc(currentpc),
      .WB_data(WB_data),
      .proc_resetl(proc_resetl),
      .proc_startpc(proc_startpc),
      .busy(busy),
      .done(done),
      .pass(pass),
      .timeout(timeout),
      .result(result),
      .cycle_count(cycle_count)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK)
      if (!proc_resetl) model_pc <= proc_startpc;
      else model_pc <= model_pc + 64'd4;

   assign currentpc = stuck ? stuck_pc : model_pc;
   assign WB_data   = (currentpc >= model_end) ? code : 64'd0;

   task automatic do_start(input logic [63:0] spc,
                           input logic [63:0] epc,
                           input logic [63:0] ex);
      @(posedge CLK); #1;
      start    = 1'b1;
      start_pc = spc;
      end_pc   = epc;
      expected = ex;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      while (done !== 1'b1 && n < bound) begin
         @(posedge CLK); #1;
         n++;
      end
   endtask

   task automatic test_reset;
      resetl = 1'b0;
      start  = 1'b0;
      start_pc = '0; end_pc = '0; expected = '0;
      stuck = 1'b0; stuck_pc = '0; model_end = 64'h34; code = 64'd12;
      #3;
      checks++;
      if ({proc_resetl, busy, done, pass, timeout, result, cycle_count,
           proc_startpc} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %b/%b/%b/%b/%b %h %h %h exp all 0",
                  proc_resetl, busy, done, pass, timeout, result,
                  cycle_count, proc_startpc);
      end
      repeat (3) @(posedge CLK);
      #1 resetl = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if ({busy, proc_resetl, done} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_reset: got busy/prst/done %b%b%b exp 000",
                  busy, proc_resetl, done);
      end
   endtask

   task automatic test_normal(input string nm);
      exp_t e;
      int   n;
      stuck = 1'b0; model_end = 64'h34; code = 64'd12;
      sb.push_back('{pass: 1'b1, timeout: 1'b0, result: 64'd12, cc: 16'd13});
      do_start(64'd0, 64'h34, 64'd12);
      checks++;
      if ({busy, proc_resetl, done} !== 3'b100) begin
         errors++;
         $display("FAIL %s_in_reset: got busy/prst/done %b%b%b exp 100",
                  nm, busy, proc_resetl, done);
      end
      wait_done(100, n);
      e = sb.pop_front();
      checks++;
      if (n !== RC + 13 + 2) begin
         errors++;
         $display("FAIL %s_latency: got %0d exp %0d", nm, n, RC + 15);
      end
      checks++;
      if ({done, pass, timeout, result, cycle_count} !==
          {1'b1, e.pass, e.timeout, e.result, e.cc}) begin
         errors++;
         $display("FAIL %s_outcome: got d%b p%b t%b r%h c%0d exp d1 p%b t%b r%h c%0d",
                  nm, done, pass, timeout, result, cycle_count,
                  e.pass, e.timeout, e.result, e.cc);
      end
      checks++;
      if ({busy, proc_resetl} !== 2'b01) begin
         errors++;
         $display("FAIL %s_done_state: got busy/prst %b%b exp 01",
                  nm, busy, proc_resetl);
      end
   endtask

   task automatic test_mismatch;
      exp_t e;
      int   n;
      stuck = 1'b0; model_end = 64'h34; code = 64'h123456789ABCDEF0;
      sb.push_back('{pass: 1'b0, timeout: 1'b0,
                     result: 64'h123456789ABCDEF0, cc: 16'd13});
      do_start(64'd0, 64'h34, 64'd12);
      wait_done(100, n);
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL mismatch_done: got %b exp 1 after %0d cycles", done, n);
      end
      checks++;
      if ({pass, timeout, result, cycle_count} !==
          {e.pass, e.timeout, e.result, e.cc}) begin
         errors++;
         $display("FAIL mismatch_outcome: got p%b t%b r%h c%0d exp p%b t%b r%h c%0d",
                  pass, timeout, result, cycle_count,
                  e.pass, e.timeout, e.result, e.cc);
      end
   endtask

   task automatic test_watchdog;
      exp_t e;
      int   n;
      stuck = 1'b1; stuck_pc = 64'h8; model_end = 64'h34; code = 64'd12;
      sb.push_back('{pass: 1'b0, timeout: 1'b1, result: 64'd0, cc: 16'd254});
      do_start(64'd0, 64'h34, 64'd12);
      wait_done(400, n);
      e = sb.pop_front();
      checks++;
      if (n !== RC + 255) begin
         errors++;
         $display("FAIL watchdog_latency: got %0d exp %0d", n, RC + 255);
      end
      checks++;
      if ({done, pass, timeout, result, cycle_count} !==
          {1'b1, e.pass, e.timeout, e.result, e.cc}) begin
         errors++;
         $display("FAIL watchdog_outcome: got d%b p%b t%b r%h c%0d exp d1 p%b t%b r%h c%0d",
                  done, pass, timeout, result, cycle_count,
                  e.pass, e.timeout, e.result, e.cc);
      end
   endtask

   task automatic test_immediate_end;
      exp_t e;
      int   n;
      stuck = 1'b1; stuck_pc = 64'd0; model_end = 64'd0; code = 64'd12;
      sb.push_back('{pass: 1'b1, timeout: 1'b0, result: 64'd12, cc: 16'd0});
      do_start(64'd0, 64'd0, 64'd12);
      wait_done(50, n);
      e = sb.pop_front();
      checks++;
      if (n !== RC + 2) begin
         errors++;
         $display("FAIL immediate_latency: got %0d exp %0d", n, RC + 2);
      end
      checks++;
      if ({done, pass, timeout, result, cycle_count} !==
          {1'b1, e.pass, e.timeout, e.result, e.cc}) begin
         errors++;
         $display("FAIL immediate_outcome: got d%b p%b t%b r%h c%0d exp d1 p%b t%b r%h c%0d",
                  done, pass, timeout, result, cycle_count,
                  e.pass, e.timeout, e.result, e.cc);
      end
   endtask

   task automatic test_start_while_busy;
      exp_t e;
      int   n;
      stuck = 1'b0; model_end = 64'h34; code = 64'd12;
      sb.push_back('{pass: 1'b1, timeout: 1'b0, result: 64'd12, cc: 16'd13});
      do_start(64'd0, 64'h34, 64'd12);
      repeat (4) @(posedge CLK);
      #1;
      start = 1'b1; start_pc = 64'h40; end_pc = 64'h100; expected = 64'd99;
      @(posedge CLK); #1;
      start = 1'b0;
      wait_done(100, n);
      e = sb.pop_front();
      checks++;
      if ({done, pass, timeout, result, cycle_count} !==
          {1'b1, e.pass, e.timeout, e.result, e.cc}) begin
         errors++;
         $display("FAIL busy_start_outcome: got d%b p%b t%b r%h c%0d exp d1 p%b t%b r%h c%0d",
                  done, pass, timeout, result, cycle_count,
                  e.pass, e.timeout, e.result, e.cc);
      end
      checks++;
      if (proc_startpc !== 64'd0) begin
         errors++;
         $display("FAIL busy_start_pc: got %h exp 0", proc_startpc);
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   n;
      stuck = 1'b0; model_end = 64'h34; code = 64'd12;
      sb.push_back('{pass: 1'b1, timeout: 1'b0, result: 64'd12, cc: 16'd5});
      do_start(64'h20, 64'h34, 64'd12);
      checks++;
      if ({done, proc_resetl, busy, proc_startpc} !== {3'b001, 64'h20}) begin
         errors++;
         $display("FAIL restart_reset: got d%b prst%b busy%b spc%h exp d0 prst0 busy1 spc20",
                  done, proc_resetl, busy, proc_startpc);
      end
      repeat (RC) @(posedge CLK);
      #1;
      checks++;
      if (proc_resetl !== 1'b1) begin
         errors++;
         $display("FAIL restart_release: got prst %b exp 1", proc_resetl);
      end
      wait_done(100, n);
      e = sb.pop_front();
      checks++;
      if (n + RC !== RC + 5 + 2) begin
         errors++;
         $display("FAIL restart_latency: got %0d exp %0d", n + RC, RC + 7);
      end
      checks++;
      if ({done, pass, timeout, result, cycle_count} !==
          {1'b1, e.pass, e.timeout, e.result, e.cc}) begin
         errors++;
         $display("FAIL restart_outcome: got d%b p%b t%b r%h c%0d exp d1 p%b t%b r%h c%0d",
                  done, pass, timeout, result, cycle_count,
                  e.pass, e.timeout, e.result, e.cc);
      end
   endtask

   task automatic test_async_reset;
      stuck = 1'b0; model_end = 64'h34; code = 64'd12;
      do_start(64'h20, 64'h34, 64'd12);
      repeat (4) @(posedge CLK);
      #3 resetl = 1'b0;
      #1;
      checks++;
      if ({proc_resetl, busy, done, pass, timeout, result, cycle_count,
           proc_startpc} !== '0) begin
         errors++;
         $display("FAIL async_reset_outputs: got %b/%b/%b/%b/%b %h %h %h exp all 0",
                  proc_resetl, busy, done, pass, timeout, result,
                  cycle_count, proc_startpc);
      end
      @(posedge CLK);
      #1 resetl = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if ({busy, proc_resetl} !== 2'b00) begin
         errors++;
         $display("FAIL async_reset_idle: got busy/prst %b%b exp 00",
                  busy, proc_resetl);
      end
   endtask

   initial begin
      test_reset();
      test_normal("normal");
      test_mismatch();
      test_watchdog();
      test_immediate_end();
      test_start_while_busy();
      test_back_to_back();
      test_async_reset();
      test_normal("after_reset");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
